// File: rtl/wport_scheduler.sv
// rtl/wport_scheduler.sv - board RAM write-port scheduler: command FIFO with priority over block fill
// Optional feature macro: WPORT_VBLANK_GATE_EN (writes gated by vblank when defined)
module wport_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_waddr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_addr,
  input  logic [AW-1:0] fill_count,
  input  logic [DW-1:0] fill_data,
  input  logic          vblank,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          cmd_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, FILL} state_t;

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  state_t           state;
  logic [AW-1:0]    f_addr;
  logic [AW:0]      f_left;
  logic [DW-1:0]    f_data;

  logic             gate;
  logic             fifo_empty;
  logic             fifo_full;
  logic             grant_cmd;
  logic             grant_fill;
  logic             fill_last;
  logic             push;
  logic [AW+DW-1:0] head;

`ifdef WPORT_VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate = 1'b1;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign head       = mem[rd_ptr];
  // Queued command writes always win; the fill only gets otherwise-idle gated cycles.
  assign grant_cmd  = !fifo_empty && gate;
  assign grant_fill = fifo_empty && gate && (state == FILL);
  assign fill_last  = grant_fill && (f_left == (AW+1)'(1));
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign push       = cmd_we && (!fifo_full || grant_cmd);

  // FIFO storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_waddr, cmd_wdata};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      cmd_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_cmd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, grant_cmd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (cmd_we && !push) begin
        cmd_overflow <= 1'b1;
      end
    end
  end

  // Fill FSM; busy stays up through the output cycle of the last fill write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      f_addr    <= '0;
      f_left    <= '0;
      f_data    <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= fill_last;
      case (state)
        IDLE: begin
          fill_busy <= fill_start;
          if (fill_start) begin
            state  <= FILL;
            f_addr <= fill_addr;
            f_data <= fill_data;
            // A zero count encodes a full sweep of the address space.
            f_left <= (fill_count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, fill_count};
          end
        end
        FILL: begin
          fill_busy <= 1'b1;
          if (grant_fill) begin
            f_addr <= f_addr + 1'b1;
            f_left <= f_left - 1'b1;
            if (fill_last) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM write port; address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= grant_cmd || grant_fill;
      if (grant_cmd) begin
        waddr <= head[AW+DW-1:DW];
        wdata <= head[DW-1:0];
      end else if (grant_fill) begin
        waddr <= f_addr;
        wdata <= f_data;
      end
    end
  end

endmodule

// File: tb/tb_wport_scheduler.sv
// tb/tb_wport_scheduler.sv - randomized + directed bench with queue-level reference model
module tb_wport_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_waddr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic [AW-1:0] fill_count = '0;
  logic [DW-1:0] fill_data = '0;
  logic          vblank = 1'b1;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          fill_busy;
  logic          fill_done;
  logic          cmd_overflow;

  int total = 0;
  int bad   = 0;

  wport_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_we(cmd_we), .cmd_waddr(cmd_waddr), .cmd_wdata(cmd_wdata),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_count(fill_count), .fill_data(fill_data),
    .vblank(vblank),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fill_busy(fill_busy), .fill_done(fill_done), .cmd_overflow(cmd_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending commands as a queue, fill as base/remaining.
  logic [AW+DW-1:0] q[$];
  bit               m_active = 0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;
  int               m_left = 0;
  bit               model_valid = 0;
  logic             e_we = 0, e_busy = 0, e_done = 0, e_ovf = 0;
  logic [AW-1:0]    e_waddr = '0;
  logic [DW-1:0]    e_wdata = '0;

  always @(posedge clk) begin : model
    bit g, was_active;
    logic [AW+DW-1:0] e;
    if (reset) begin
      q.delete();
      m_active = 0; m_left = 0;
      e_we = 0; e_waddr = '0; e_wdata = '0; e_busy = 0; e_done = 0; e_ovf = 0;
    end else begin
`ifdef WPORT_VBLANK_GATE_EN
      g = vblank;
`else
      g = 1;
`endif
      was_active = m_active;
      e_we = 0;
      e_done = 0;
      if (q.size() > 0 && g) begin
        e = q.pop_front();
        e_we = 1; e_waddr = e[AW+DW-1:DW]; e_wdata = e[DW-1:0];
      end else if (m_active && g) begin
        e_we = 1; e_waddr = m_addr; e_wdata = m_data;
        m_addr = m_addr + 1'b1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = 0;
          e_done = 1;
        end
      end
      if (cmd_we) begin
        if (q.size() < DEPTH) q.push_back({cmd_waddr, cmd_wdata});
        else e_ovf = 1;
      end
      if (!was_active && fill_start) begin
        m_active = 1; m_addr = fill_addr; m_data = fill_data;
        m_left = (fill_count == 0) ? (1 << AW) : int'(fill_count);
      end
      e_busy = m_active || e_done;
    end
    model_valid = 1;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("we", 32'(we), 32'(e_we));
      check("waddr", 32'(waddr), 32'(e_waddr));
      check("wdata", 32'(wdata), 32'(e_wdata));
      check("fill_busy", 32'(fill_busy), 32'(e_busy));
      check("fill_done", 32'(fill_done), 32'(e_done));
      check("cmd_overflow", 32'(cmd_overflow), 32'(e_ovf));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_we = 0; fill_start = 0; vblank = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  bit seen[1 << AW];

  initial begin : stim
    int nwr, nfill, ndone, uniq;
    bit got;
    reset = 1;
    repeat (3) step();
    check("rst_we", 32'(we), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_busy", 32'(fill_busy), 0);
    check("rst_done", 32'(fill_done), 0);
    check("rst_ovf", 32'(cmd_overflow), 0);
    reset = 0;
    idle(2);

    // Single command write: visible two cycles after the strobe.
    cmd_we = 1; cmd_waddr = 10'h005; cmd_wdata = 8'h3C;
    step();
    cmd_we = 0;
    check("cmd_lat_n1", 32'(we), 0);
    step();
    check("cmd_we_n2", 32'(we), 1);
    check("cmd_addr_n2", 32'(waddr), 32'h005);
    check("cmd_data_n2", 32'(wdata), 32'h3C);
    step();
    check("cmd_after", 32'(we), 0);
    idle(2);

    // Fill wrapping through the top of the address space.
    fill_start = 1; fill_addr = 10'h3FE; fill_count = 10'd4; fill_data = 8'h00;
    step();
    fill_start = 0;
    check("fill_busy_n1", 32'(fill_busy), 1);
    check("fill_we_n1", 32'(we), 0);
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      a = 10'h3FE + 10'(i);
      step();
      check("fill_we", 32'(we), 1);
      check("fill_addr", 32'(waddr), 32'(a));
      check("fill_busy", 32'(fill_busy), 1);
      check("fill_done", 32'(fill_done), (i == 3) ? 1 : 0);
    end
    step();
    check("fill_busy_end", 32'(fill_busy), 0);
    check("fill_we_end", 32'(we), 0);
    idle(2);

    // Command writes preempting a 10-cell fill.
    fill_start = 1; fill_addr = 10'h100; fill_count = 10'd10; fill_data = 8'hA5;
    step();
    fill_start = 0;
    nwr = 0; nfill = 0; got = 0;
    for (int c = 1; c < 40 && !got; c++) begin
      cmd_we = (c == 2 || c == 4 || c == 6);
      cmd_waddr = 10'h200 + 10'(c); cmd_wdata = 8'(c);
      step();
      if (we) begin
        nwr++;
        if (waddr >= 10'h100 && waddr < 10'h10A) nfill++;
      end
      if (fill_done) begin
        got = 1;
        check("preempt_done_on_fill", 32'(waddr), 32'h109);
      end
    end
    cmd_we = 0;
    check("preempt_done_seen", 32'(got), 1);
    check("preempt_total", 32'(nwr), 13);
    check("preempt_fill", 32'(nfill), 10);
    idle(3);

`ifdef WPORT_VBLANK_GATE_EN
    // Closed gate: FIFO fills, overflow sticks, order kept on reopen.
    vblank = 0;
    fill_start = 1; fill_addr = 10'h050; fill_count = 10'd3; fill_data = 8'h77;
    step();
    fill_start = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_we = 1; cmd_waddr = 10'h020 + 10'(i); cmd_wdata = 8'(i);
      step();
    end
    cmd_we = 0;
    step();
    check("gate_ovf", 32'(cmd_overflow), 1);
    check("gate_held", 32'(we), 0);
    vblank = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("gate_we", 32'(we), 1);
      check("gate_order", 32'(waddr), 32'(10'h020 + 10'(i)));
    end
    idle(6);
    reset = 1; step(); reset = 0; step();
`endif

    // Reset mid-fill: write stops, no done pulse, FIFO left empty.
    fill_start = 1; fill_addr = 10'h010; fill_count = 10'd100; fill_data = 8'h11;
    step();
    fill_start = 0;
    nwr = 0;
    for (int c = 0; c < 10 && nwr < 2; c++) begin
      step();
      if (we) nwr++;
    end
    check("rst_mid_seen2", 32'(nwr), 2);
    reset = 1;
    step();
    check("rst_mid_we", 32'(we), 0);
    check("rst_mid_busy", 32'(fill_busy), 0);
    check("rst_mid_done", 32'(fill_done), 0);
    reset = 0;
    nwr = 0; ndone = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (we) nwr++;
      if (fill_done) ndone++;
    end
    check("rst_mid_quiet", 32'(nwr), 0);
    check("rst_mid_nodone", 32'(ndone), 0);

    // Count of zero sweeps all 1024 addresses.
    for (int i = 0; i < (1 << AW); i++) seen[i] = 0;
    fill_start = 1; fill_addr = 10'h123; fill_count = 10'd0; fill_data = 8'h5A;
    step();
    fill_start = 0;
    nwr = 0; ndone = 0;
    for (int c = 0; c < 1100; c++) begin
      step();
      if (we) begin nwr++; seen[waddr] = 1; end
      if (fill_done) ndone++;
    end
    uniq = 0;
    for (int i = 0; i < (1 << AW); i++) if (seen[i]) uniq++;
    check("full_writes", 32'(nwr), 1024);
    check("full_unique", 32'(uniq), 1024);
    check("full_done", 32'(ndone), 1);
    check("full_idle", 32'(fill_busy), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      cmd_we     = ($urandom_range(0, 2) == 0);
      cmd_waddr  = AW'($urandom);
      cmd_wdata  = DW'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_addr  = AW'($urandom);
      fill_count = AW'($urandom_range(1, 12));
      fill_data  = DW'($urandom);
      vblank     = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
